apb_master_nslv: RTL

//  Parametrised APB3 master bridging a valid/ready command port to NUM_SLV APB slaves.

---
 rtl/apb_master_nslv.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_nslv.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_nslv
//  Description : APB3 master bridging a valid/ready command port to NUM_SLV
//                APB slaves. The upper address bits select the slave. Each
//                transfer runs IDLE->SETUP->ACCESS with pready wait states.
//                Read data and error status return as a one-cycle response.
//                Optional feature macro: APB_TIMEOUT_EN (ACCESS-phase timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_nslv #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 8,
    parameter int NUM_SLV     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_SLV-1:0]  w_psel_nxt;
    logic                w_penable_nxt;
    logic                w_pwrite_nxt;
    logic [ADDR_W-1:0]   w_paddr_nxt;
    logic [DATA_W-1:0]   w_pwdata_nxt;
    logic                w_rsp_valid_nxt;
    logic                w_rsp_err_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;

    logic [SEL_W-1:0]    w_cmd_idx;
    logic                w_cmd_hit;
    logic [NUM_SLV-1:0]  w_cmd_onehot;
    logic                w_sel_ready;
    logic                w_sel_err;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic                w_timeout;

    // Slave index lives in the top address bits; indices past NUM_SLV are decode errors
    assign w_cmd_idx = cmd_addr[ADDR_W-1 -: SEL_W];
    assign w_cmd_hit = (32'(w_cmd_idx) < 32'(NUM_SLV));

    // Only the slave currently selected by psel may complete or fail the transfer
    assign w_sel_ready = |(pready & psel);
    assign w_sel_err   = |(pslverr & psel);

    // One-hot decode of the incoming command and read-data mux keyed by the live psel
    always_comb begin
        w_cmd_onehot = '0;
        w_sel_rdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_cmd_idx == SEL_W'(i)) begin
                w_cmd_onehot[i] = 1'b1;
            end
            if (psel[i]) begin
                w_sel_rdata = w_sel_rdata | prdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Give up on the last unanswered ACCESS cycle; a pready in that cycle still wins
    assign w_timeout = (r_state == ACCESS) && !w_sel_ready &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Count unanswered ACCESS cycles of the current transfer, cleared on SETUP entry
    always_ff @(posedge pclk) begin
        if (preset || (w_state_nxt == SETUP)) begin
            r_to_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_sel_ready) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    // No timeout: ACCESS waits for pready indefinitely (always false for legal TIMEOUT_CYC)
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Next state and next register values; an accepted command overrides the return to IDLE
    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = psel;
        w_penable_nxt   = penable;
        w_pwrite_nxt    = pwrite;
        w_paddr_nxt     = paddr;
        w_pwdata_nxt    = pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        cmd_ready       = 1'b0;

        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (w_sel_ready) begin
                    cmd_ready       = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_sel_err;
                    if (!pwrite && !w_sel_err) begin
                        w_rsp_rdata_nxt = w_sel_rdata;
                    end
                    w_state_nxt   = IDLE;
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = IDLE;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                end
            end
            DERR: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = 1'b1;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (cmd_valid && cmd_ready) begin
            w_pwrite_nxt  = cmd_write;
            w_paddr_nxt   = cmd_addr;
            w_pwdata_nxt  = cmd_wdata;
            w_penable_nxt = 1'b0;
            if (w_cmd_hit) begin
                w_state_nxt = SETUP;
                w_psel_nxt  = w_cmd_onehot;
            end else begin
                w_state_nxt = DERR;
                w_psel_nxt  = '0;
            end
        end
    end

    // State and registered APB/response outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= IDLE;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            psel      <= w_psel_nxt;
            penable   <= w_penable_nxt;
            pwrite    <= w_pwrite_nxt;
            paddr     <= w_paddr_nxt;
            pwdata    <= w_pwdata_nxt;
            rsp_valid <= w_rsp_valid_nxt;
            rsp_err   <= w_rsp_err_nxt;
            rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

endmodule
`default_nettype wire
